piso_tx_sched: RTL and testbench

- Sequencer for the 4-bit parallel-in/serial-out shift register (DFF/TFF-based `top` datapath).
- Accepts parallel words from upstream over a valid/ready handshake into a small FIFO.
- Drives the register's load strobe and parallel input, then times each shift window and the inter-word gap.
- Flags when the serial output carries valid data bits and counts completed words.

---
 rtl/piso_tx_sched_if.sv | 16 +
 rtl/piso_tx_sched.sv | 191 +++++++++++++++++++
 tb/tb_piso_tx_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_sched_if.sv
// piso_tx_sched_if
// Upstream word handshake into the PISO sequencer.
//   in_valid : upstream word valid
//   in_data  : upstream word (WIDTH bits)
//   in_ready : sequencer FIFO can accept a word
// master = upstream source, slave = piso_tx_sched.
interface piso_tx_sched_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/piso_tx_sched.sv
// piso_tx_sched
// Sequencer for a WIDTH-bit parallel-in/serial-out shift register. Words are
// buffered in a DEPTH-entry FIFO, presented on pi with a one-cycle load
// strobe, then the WIDTH-cycle shift window and a GAP-cycle idle gap are
// timed. Optional parity slot enabled by macro PISO_PARITY_EN.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   up          : upstream valid/ready/data (slave modport)
//   load        : shift register load strobe
//   pi          : parallel word to the shift register
//   ser_valid   : serial output carries a data bit
//   bit_idx     : index of current serial bit (0 = first out)
//   busy        : sequencer not idle
//   word_done   : one-cycle pulse after the last bit (or parity) of a word
//   words_sent  : completed-word counter, wraps
//   par_bit     : (PISO_PARITY_EN only) word parity, high only in PAR
module piso_tx_sched #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  piso_tx_sched_if.slave           up,
  output logic                     load,
  output logic [WIDTH-1:0]         pi,
  output logic                     ser_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     word_done,
  output logic [7:0]               words_sent
`ifdef PISO_PARITY_EN
  ,
  output logic                     par_bit
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  // Gap timer is a down-counter loaded with GAP-1 on entry.
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
`ifdef PISO_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = (GAP == 0) ? S_IDLE : S_GAP;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             load_q, load_d;
  logic [WIDTH-1:0] pi_q, pi_d;
  logic             sv_q, sv_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             wd_q, wd_d;
  logic [7:0]       ws_q, ws_d;
  logic [GW-1:0]    gap_q, gap_d;
`ifdef PISO_PARITY_EN
  logic             pword_q, pword_d;
  logic             par_q, par_d;
`endif

  logic push, pop;
  assign up.in_ready = (count_q != (AW+1)'(DEPTH));
  assign push = up.in_valid && up.in_ready;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    pi_d    = pi_q;
    sv_d    = sv_q;
    idx_d   = idx_q;
    wd_d    = 1'b0;
    ws_d    = ws_q;
    gap_d   = gap_q;
`ifdef PISO_PARITY_EN
    pword_d = pword_q;
    par_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
          pi_d    = mem_q[rd_ptr_q];
`ifdef PISO_PARITY_EN
          pword_d = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        sv_d    = 1'b1;
        idx_d   = '0;
      end
      S_SHIFT: begin
        if (idx_q == IW'(WIDTH - 1)) begin
          sv_d  = 1'b0;
          idx_d = '0;
`ifdef PISO_PARITY_EN
          state_d = S_PAR;
          par_d   = pword_q;
`else
          state_d = S_DONE;
          gap_d   = GAP_LAST;
          wd_d    = 1'b1;
          ws_d    = ws_q + 8'd1;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`ifdef PISO_PARITY_EN
      S_PAR: begin
        state_d = S_DONE;
        gap_d   = GAP_LAST;
        wd_d    = 1'b1;
        ws_d    = ws_q + 8'd1;
      end
`endif
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FIFO storage carries data only; validity lives in count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= up.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      load_q   <= 1'b0;
      pi_q     <= '0;
      sv_q     <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      wd_q     <= 1'b0;
      ws_q     <= '0;
      gap_q    <= '0;
`ifdef PISO_PARITY_EN
      pword_q  <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      load_q  <= load_d;
      pi_q    <= pi_d;
      sv_q    <= sv_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      wd_q    <= wd_d;
      ws_q    <= ws_d;
      gap_q   <= gap_d;
`ifdef PISO_PARITY_EN
      pword_q <= pword_d;
      par_q   <= par_d;
`endif
    end
  end

  assign load       = load_q;
  assign pi         = pi_q;
  assign ser_valid  = sv_q;
  assign bit_idx    = idx_q;
  assign busy       = busy_q;
  assign word_done  = wd_q;
  assign words_sent = ws_q;
`ifdef PISO_PARITY_EN
  assign par_bit    = par_q;
`endif
endmodule

// File: tb/tb_piso_tx_sched.sv
module tb_piso_tx_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       load, ser_valid, busy, word_done;
  logic [3:0] pi;
  logic [1:0] bit_idx;
  logic [7:0] words_sent;
`ifdef PISO_PARITY_EN
  logic       par_bit;
  localparam int PER = 9;
  localparam int NV  = 11;
`else
  localparam int PER = 8;
  localparam int NV  = 10;
`endif

  int checks   = 0;
  int failures = 0;

  piso_tx_sched_if #(.WIDTH(4)) up_if ();

  piso_tx_sched #(.WIDTH(4), .DEPTH(2), .GAP(2)) dut (
    .clk(clk), .reset(reset), .up(up_if),
    .load(load), .pi(pi), .ser_valid(ser_valid), .bit_idx(bit_idx),
    .busy(busy), .word_done(word_done), .words_sent(words_sent)
`ifdef PISO_PARITY_EN
    , .par_bit(par_bit)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       iv;
    logic [3:0] din;
    logic       ld;
    logic [3:0] pi;
    logic       sv;
    logic [1:0] idx;
    logic       bsy;
    logic       wd;
    logic [7:0] ws;
    logic       rdy;
    logic       par;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    up_if.in_valid = 1'b0;
    up_if.in_data  = 4'h0;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " load"}, load, 0);
    chk({tag, " pi"}, pi, 0);
    chk({tag, " ser_valid"}, ser_valid, 0);
    chk({tag, " bit_idx"}, bit_idx, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " word_done"}, word_done, 0);
    chk({tag, " words_sent"}, words_sent, 0);
    chk({tag, " in_ready"}, up_if.in_ready, 1);
`ifdef PISO_PARITY_EN
    chk({tag, " par_bit"}, par_bit, 0);
`endif
  endtask

  initial begin
    logic [3:0] words [4];
    int t, widx, nload, cnt;
    logic pushed, saw_full, saw_both, seen_load;

    // Single word 1011: per-cycle inputs and outputs after the edge.
    //             iv   din    ld   pi     sv   idx  bsy  wd   ws  rdy  par
    vecs[0] = '{1'b1, 4'hB, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'h0, 1'b1, 4'hB, 1'b0, 2'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b1, 2'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b1, 2'd3, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
`ifdef PISO_PARITY_EN
    vecs[6] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0};
`else
    vecs[6] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0};
`endif

    // Reset state
    do_reset();
    chk_zero("reset");

    // Single word table
    for (int i = 0; i < NV; i++) begin
      up_if.in_valid = vecs[i].iv;
      up_if.in_data  = vecs[i].din;
      step();
      chk($sformatf("v%0d load", i), load, vecs[i].ld);
      chk($sformatf("v%0d pi", i), pi, vecs[i].pi);
      chk($sformatf("v%0d ser_valid", i), ser_valid, vecs[i].sv);
      if (vecs[i].sv) chk($sformatf("v%0d bit_idx", i), bit_idx, vecs[i].idx);
      chk($sformatf("v%0d busy", i), busy, vecs[i].bsy);
      chk($sformatf("v%0d word_done", i), word_done, vecs[i].wd);
      chk($sformatf("v%0d words_sent", i), words_sent, vecs[i].ws);
      chk($sformatf("v%0d in_ready", i), up_if.in_ready, vecs[i].rdy);
`ifdef PISO_PARITY_EN
      chk($sformatf("v%0d par_bit", i), par_bit, vecs[i].par);
`endif
    end

    // Two words on consecutive cycles: load-to-load period
    do_reset();
    up_if.in_valid = 1'b1;
    up_if.in_data  = 4'hB;
    chk("b2b ready0", up_if.in_ready, 1);
    step();
    up_if.in_data = 4'hC;
    chk("b2b ready1", up_if.in_ready, 1);
    step();
    up_if.in_valid = 1'b0;
    chk("b2b load1", load, 1);
    chk("b2b pi1", pi, 4'hB);
    t = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      t++;
      if (load) break;
    end
    chk("b2b period", t, PER);
    chk("b2b load2", load, 1);
    chk("b2b pi2", pi, 4'hC);
    for (int k = 0; k < 12; k++) step();
    chk("b2b words_sent", words_sent, 2);
    chk("b2b busy", busy, 0);

    // Streaming with in_valid held high
    do_reset();
    words[0] = 4'h1; words[1] = 4'h6; words[2] = 4'hA; words[3] = 4'hF;
    widx = 0; nload = 0; cnt = 0;
    saw_full = 1'b0; saw_both = 1'b0;
    for (int cyc = 0; cyc < 80 && nload < 4; cyc++) begin
      up_if.in_valid = (widx < 4);
      up_if.in_data  = (widx < 4) ? words[widx] : 4'h0;
      pushed = up_if.in_valid && up_if.in_ready;
      step();
      if (pushed) begin
        widx++;
        cnt++;
      end
      if (load) begin
        chk($sformatf("stream pi%0d", nload), pi, words[nload]);
        nload++;
        cnt--;
        if (pushed) saw_both = 1'b1;
      end
      chk($sformatf("stream ready c%0d", cyc), up_if.in_ready, (cnt != 2));
      if (cnt == 2) saw_full = 1'b1;
    end
    up_if.in_valid = 1'b0;
    chk("stream loads", nload, 4);
    chk("stream pushes", widx, 4);
    chk("stream saw_full", saw_full, 1);
    chk("stream push_pop_same_edge", saw_both, 1);
    for (int k = 0; k < 14; k++) step();
    chk("stream words_sent", words_sent, 4);

    // Reset during SHIFT at bit_idx 2, with a second word queued
    do_reset();
    up_if.in_valid = 1'b1;
    up_if.in_data  = 4'hB;
    step();
    up_if.in_data = 4'h3;
    step();
    up_if.in_valid = 1'b0;
    t = 0;
    while (!(ser_valid && bit_idx == 2) && t < 10) begin
      step();
      t++;
    end
    chk("abort reached bit2", (ser_valid && bit_idx == 2), 1);
    chk("abort ws before", words_sent, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("abort");
    seen_load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (load) seen_load = 1'b1;
    end
    chk("abort fifo flushed", seen_load, 0);
    chk("abort ws after", words_sent, 0);
    chk("abort busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
